serial_cmd_processor_v2: RTL and testbench
==========================================

// Module: serial_cmd_processor_v2
// PURPOSE
//  Parametrised successor of the board's UART command processor. It decodes command bytes plus
//  little-endian argument bytes from the UART rx side and holds the trigger configuration registers.
//  It snapshots histogram and counter inputs and streams the replies back through the UART tx side.
//  Adds: parametrised histo count/width and mask width, an inter-byte timeout, and a saturating error counter.
// PARAMETERS
//  N_HISTOS        8         number of histogram words
//  HISTO_W         32        bits per histogram word (multiple of 8)
//  MASK_BYTES      8         trigger mask width in bytes
//  FW_VERSION      8'd9      byte returned by cmd 0x00
//  TIMEOUT_CYCLES  1000000   idle cycles allowed between argument bytes
// PORTS
//  clk              in   1                     system clock
//  reset            in   1                     synchronous, active-high reset
//  rx_ready         in   1                     1-cycle strobe: rx_data valid
//  rx_data          in   8                     received byte
//  tx_busy          in   1                     UART transmitter busy
//  tx_start         out  1                     1-cycle strobe: send tx_data
//  tx_data          out  8                     byte to send
//  histos           in   N_HISTOS*HISTO_W      flattened histos; word k = [k*HISTO_W +: HISTO_W]
//  clock_counter    in   56                    free-running cycle counter
//  trigger_fired    in   8                     last trigger id fired
//  coincidence_time out  8                     reset value 20
//  dead_time        out  8                     reset value 50
//  prescale         out  32                    reset value 32'hFFFFFFFF
//  trigger_mask     out  8*MASK_BYTES          reset value all ones
//  trigger_number   out  8                     reset value 2
//  reset_hist       out  1                     1-cycle pulse, reset value 0
//  reset_clock      out  1                     1-cycle pulse, reset value 0
//  busy             out  1                     high whenever state != IDLE, reset value 0
// BEHAVIOUR
//  States: IDLE, ARGS, EXEC, SNAP, TX_LOAD, TX_GAP.
//  - IDLE: on rx_ready, latch cmd. Go to ARGS if the argument count is >0, else EXEC.
//  - ARGS: store bytes LE into arg buffer. When the count is reached, go to EXEC.
//    The timer clears on each byte; at TIMEOUT_CYCLES idle cycles, go to IDLE, discard the command, err_cnt++.
//  - EXEC (1 cycle) applies the command:
//    0x00: reply FW_VERSION (1 byte).
//    0x01 (1 arg): coincidence_time = arg if arg<64, else ignored with err_cnt++.
//    0x07 (4 args): prescale. 0x0B (1 arg): dead_time.
//    0x0E (MASK_BYTES args): trigger_mask. 0x0F (1 arg): trigger_number = arg if nonzero.
//    0x0A: snapshot histos -> SNAP, which pulses reset_hist for 1 cycle, then reply N_HISTOS*HISTO_W/8 bytes, LSB of word 0 first.
//    0x10: reply 8 bytes: clock_counter bytes 0..6, then trigger_fired; all sampled in EXEC.
//    0x11: pulse reset_clock in SNAP, then reply 8'h01.
//    0x12: reply err_cnt.
//    Any other cmd: err_cnt++, back to IDLE.
//  - Config writes take effect at the end of the EXEC cycle. Commands with no reply return to IDLE.
//  - TX_LOAD: wait for !tx_busy, then drive tx_data and assert tx_start for exactly 1 cycle -> TX_GAP.
//    TX_GAP holds tx_start=0 for 1 cycle, then either the next byte goes to TX_LOAD, or the last byte goes to IDLE.
//  - Reply data comes from the snapshot registers, which are stable during streaming.
//  - rx_ready outside IDLE/ARGS: byte dropped, err_cnt++.
//  - err_cnt: 8-bit, saturates at 255, cleared by reset and by cmd 0x12 after its reply.
//  - A simultaneous rx_ready and timeout expiry in ARGS counts as a received byte.
//  - reset mid-command or mid-reply: every output and register returns to its reset value next cycle; the reply is truncated.
// CONFIGURATION
//  CMD_CHECKSUM_EN defined: every reply gets one extra trailing byte = XOR of all reply bytes.
//    Cmd 0x00 therefore replies {FW_VERSION, FW_VERSION}.
//  CMD_CHECKSUM_EN undefined: replies are exactly the lengths listed above; no checksum logic.
// TESTING
//  1. reset -> coincidence_time=20, dead_time=50, prescale=FFFFFFFF, mask all ones, trigger_number=2, tx_start=0.
//  2. rx 0x07,0x78,0x56,0x34,0x12 -> prescale=32'h12345678, no tx_start.
//  3. rx 0x01,0x50 -> coincidence_time stays 20; then 0x12 -> tx 8'h01. Repeat 0x12 -> tx 8'h00.
//  4. histos word0=32'hA1B2C3D4, rx 0x0A -> reset_hist 1-cycle pulse; tx D4,C3,B2,A1,... totalling 32 bytes.
//     Hold tx_busy high 10 cycles before each byte: no byte is lost or duplicated.
//  5. rx 0x0E followed by 3 bytes, then silence for TIMEOUT_CYCLES -> back to IDLE, mask unchanged, err_cnt=1.
//  6. Assert reset during byte 5 of 0x10 reply -> tx_start=0 next cycle, busy=0, and the next 0x00 replies normally.

Source files
------------

// File: rtl/serial_cmd_processor_v2.sv
// serial_cmd_processor_v2: UART command decoder, trigger config registers and reply streamer
// Defining CMD_CHECKSUM_EN appends an XOR checksum byte to every reply.
module serial_cmd_processor_v2 #(
    parameter int         N_HISTOS       = 8,
    parameter int         HISTO_W        = 32,
    parameter int         MASK_BYTES     = 8,
    parameter logic [7:0] FW_VERSION     = 8'd9,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_ready,
    input  logic [7:0]                  rx_data,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    input  logic [N_HISTOS*HISTO_W-1:0] histos,
    input  logic [55:0]                 clock_counter,
    input  logic [7:0]                  trigger_fired,
    output logic [7:0]                  coincidence_time,
    output logic [7:0]                  dead_time,
    output logic [31:0]                 prescale,
    output logic [8*MASK_BYTES-1:0]     trigger_mask,
    output logic [7:0]                  trigger_number,
    output logic                        reset_hist,
    output logic                        reset_clock,
    output logic                        busy
);
    localparam int HB = N_HISTOS * HISTO_W / 8;
    localparam int RB = HB > 8 ? HB : 8;
    localparam int AB = MASK_BYTES > 4 ? MASK_BYTES : 4;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(RB + 2);
    localparam logic [IW-1:0] CK = `ifdef CMD_CHECKSUM_EN IW'(1) `else IW'(0) `endif;

    typedef enum logic [2:0] {IDLE, ARGS, EXEC, SNAP, TX_LOAD, TX_GAP} state_t;
    state_t state, state_nx;

    logic [7:0]      cmd, err_cnt, arg_left, n_args, arg1;
    logic [AB*8-1:0] arg_buf;
    logic [RB*8-1:0] reply_buf;
    logic [TW-1:0]   timer;
    logic [IW-1:0]   tx_idx, tx_len;
    logic            timeout, rx_bad, exec_err, done, has_reply, needs_snap;
    logic [1:0]      err_inc;
    logic [8:0]      err_sum;

    assign n_args = (rx_data == 8'h01 || rx_data == 8'h0B || rx_data == 8'h0F) ? 8'd1 :
                    rx_data == 8'h07 ? 8'd4 : rx_data == 8'h0E ? 8'(MASK_BYTES) : 8'd0;
    // arguments are shifted in from the top, so the newest byte is the most significant
    assign arg1       = arg_buf[AB*8-1 -: 8];
    assign timeout    = state == ARGS && !rx_ready && timer == TW'(TIMEOUT_CYCLES - 1);
    assign rx_bad     = rx_ready && state != IDLE && state != ARGS;
    assign has_reply  = cmd inside {8'h00, 8'h0A, 8'h10, 8'h11, 8'h12};
    assign needs_snap = cmd inside {8'h0A, 8'h11};
    assign exec_err   = state == EXEC && (cmd == 8'h01 ? arg1 >= 8'd64 :
                        !(has_reply || cmd inside {8'h07, 8'h0B, 8'h0E, 8'h0F}));
    assign err_inc    = {1'b0, rx_bad} + {1'b0, exec_err} + {1'b0, timeout};
    assign err_sum    = {1'b0, err_cnt} + {7'b0, err_inc};
    assign done       = tx_idx == tx_len;
    assign tx_start   = state == TX_LOAD && !tx_busy;
    assign reset_hist = state == SNAP && cmd == 8'h0A;
    assign reset_clock = state == SNAP && cmd == 8'h11;
    assign busy       = state != IDLE;

`ifdef CMD_CHECKSUM_EN
    logic [7:0] chk;
    assign tx_data = (tx_idx == tx_len - 1'b1) ? chk : reply_buf[7:0];
`else
    assign tx_data = reply_buf[7:0];
`endif

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rx_ready ? (n_args != 8'd0 ? ARGS : EXEC) : IDLE;
            ARGS:    state_nx = (rx_ready && arg_left == 8'd1) ? EXEC : timeout ? IDLE : ARGS;
            EXEC:    state_nx = has_reply ? (needs_snap ? SNAP : TX_LOAD) : IDLE;
            SNAP:    state_nx = TX_LOAD;
            TX_LOAD: state_nx = tx_busy ? TX_LOAD : TX_GAP;
            TX_GAP:  state_nx = done ? IDLE : TX_LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd              <= '0;
            arg_left         <= '0;
            arg_buf          <= '0;
            timer            <= '0;
            reply_buf        <= '0;
            tx_idx           <= '0;
            tx_len           <= '0;
            err_cnt          <= '0;
            coincidence_time <= 8'd20;
            dead_time        <= 8'd50;
            prescale         <= '1;
            trigger_mask     <= '1;
            trigger_number   <= 8'd2;
`ifdef CMD_CHECKSUM_EN
            chk              <= '0;
`endif
        end else begin
            if (state == IDLE && rx_ready) begin
                cmd      <= rx_data;
                arg_left <= n_args;
            end
            timer <= (state == ARGS && !rx_ready) ? timer + 1'b1 : '0;
            if (state == ARGS && rx_ready) begin
                arg_buf  <= {rx_data, arg_buf[AB*8-1:8]};
                arg_left <= arg_left - 1'b1;
            end
            if (state == EXEC) begin
                case (cmd)
                    8'h01: coincidence_time <= arg1 < 8'd64 ? arg1 : coincidence_time;
                    8'h07: prescale <= arg_buf[AB*8-1 -: 32];
                    8'h0B: dead_time <= arg1;
                    8'h0E: trigger_mask <= arg_buf[AB*8-1 -: 8*MASK_BYTES];
                    8'h0F: trigger_number <= arg1 != 8'd0 ? arg1 : trigger_number;
                    default: ;
                endcase
                reply_buf <= cmd == 8'h0A ? (RB*8)'(histos) :
                             cmd == 8'h10 ? (RB*8)'({trigger_fired, clock_counter}) :
                             cmd == 8'h11 ? (RB*8)'(8'h01) :
                             cmd == 8'h12 ? (RB*8)'(err_cnt) : (RB*8)'(FW_VERSION);
                tx_len <= (cmd == 8'h0A ? IW'(HB) : cmd == 8'h10 ? IW'(8) : IW'(1)) + CK;
                tx_idx <= '0;
`ifdef CMD_CHECKSUM_EN
                chk    <= '0;
`endif
            end
            if (tx_start) begin
                tx_idx    <= tx_idx + 1'b1;
                reply_buf <= reply_buf >> 8;
`ifdef CMD_CHECKSUM_EN
                chk       <= chk ^ tx_data;
`endif
            end
            if (state == TX_GAP && done && cmd == 8'h12)
                err_cnt <= '0;
            else if (err_inc != 2'd0)
                err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
endmodule

// File: tb/tb_serial_cmd_processor_v2.sv
// tb_serial_cmd_processor_v2: scoreboard bench with a behavioural model of the command set
module tb_serial_cmd_processor_v2;
    localparam int T  = 300;
    localparam int NH = 8;
    localparam int HW = 32;
    localparam int MB = 8;
    localparam int HB = NH * HW / 8;
    localparam logic [7:0] FW = 8'd9;
`ifdef CMD_CHECKSUM_EN
    localparam int CKB = 1;
`else
    localparam int CKB = 0;
`endif

    logic clk = 0, reset = 1, rx_ready = 0, tx_busy = 0;
    logic [7:0] rx_data = 0, trigger_fired = 0;
    logic [NH*HW-1:0] histos = '0;
    logic [55:0] clock_counter = '0;
    logic tx_start, reset_hist, reset_clock, busy;
    logic [7:0] tx_data, coincidence_time, dead_time, trigger_number;
    logic [31:0] prescale;
    logic [8*MB-1:0] trigger_mask;

    serial_cmd_processor_v2 #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .histos(histos), .clock_counter(clock_counter), .trigger_fired(trigger_fired),
        .coincidence_time(coincidence_time), .dead_time(dead_time), .prescale(prescale),
        .trigger_mask(trigger_mask), .trigger_number(trigger_number),
        .reset_hist(reset_hist), .reset_clock(reset_clock), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int tx_cnt = 0, hist_p = 0, clk_p = 0, bcnt = 0, slow = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rq[$];
    logic [7:0] m_ct, m_dt, m_tn, m_err, c;
    logic [31:0] m_ps;
    logic [8*MB-1:0] m_mask;
    int base, n, t0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // monitor and UART transmitter model share one process so tx_busy never races tx_start
    always @(negedge clk) begin
        if (reset_hist) hist_p++;
        if (reset_clock) clk_p++;
        if (tx_start) begin
            tx_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL tx_unexpected: got byte %0h, required none", tx_data);
            end else
                chk("tx_byte", tx_data, exp_q.pop_front());
            bcnt = slow != 0 ? 10 : $urandom_range(0, 3);
        end else if (bcnt > 0)
            bcnt--;
        tx_busy = bcnt != 0;
    end

    function automatic int nargs(input logic [7:0] cc);
        return (cc == 8'h01 || cc == 8'h0B || cc == 8'h0F) ? 1 : cc == 8'h07 ? 4 : cc == 8'h0E ? MB : 0;
    endfunction

    task automatic model_reset();
        m_ct = 20; m_dt = 50; m_ps = '1; m_mask = '1; m_tn = 2; m_err = 0;
    endtask

    task automatic err_inc();
        m_err = m_err == 8'hFF ? 8'hFF : m_err + 8'd1;
    endtask

    task automatic push_rq();
        logic [7:0] x = 0;
        foreach (rq[i]) begin
            exp_q.push_back(rq[i]);
            x ^= rq[i];
        end
        if (CKB != 0) exp_q.push_back(x);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_ready = 1; rx_data = b;
        @(posedge clk); #1 rx_ready = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 5000);
        chk("idle_wait", busy, 0);
    endtask

    task automatic check_cfg();
        chk("coincidence_time", coincidence_time, m_ct);
        chk("dead_time", dead_time, m_dt);
        chk("prescale", prescale, m_ps);
        chk("trigger_mask", trigger_mask, m_mask);
        chk("trigger_number", trigger_number, m_tn);
    endtask

    task automatic run_cmd(input logic [7:0] cc, input logic [63:0] a);
        int h0 = hist_p, c0 = clk_p, eh = 0, ec = 0;
        send(cc);
        for (int i = 0; i < nargs(cc); i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(a[8*i +: 8]);
        end
        rq.delete();
        case (cc)
            8'h00: rq.push_back(FW);
            8'h01: if (a[7:0] < 64) m_ct = a[7:0]; else err_inc();
            8'h07: m_ps = a[31:0];
            8'h0B: m_dt = a[7:0];
            8'h0E: m_mask = a[8*MB-1:0];
            8'h0F: if (a[7:0] != 0) m_tn = a[7:0];
            8'h0A: begin
                for (int k = 0; k < HB; k++) rq.push_back(histos[8*k +: 8]);
                eh = 1;
            end
            8'h10: begin
                for (int k = 0; k < 7; k++) rq.push_back(clock_counter[8*k +: 8]);
                rq.push_back(trigger_fired);
            end
            8'h11: begin rq.push_back(8'h01); ec = 1; end
            8'h12: rq.push_back(m_err);
            default: err_inc();
        endcase
        if (rq.size() != 0) push_rq();
        if (cc == 8'h12) m_err = 0;
        wait_idle();
        chk("reply_drained", exp_q.size(), 0);
        chk("reset_hist_pulses", hist_p - h0, eh);
        chk("reset_clock_pulses", clk_p - c0, ec);
        check_cfg();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_cfg();
        chk("reset_tx_start", tx_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {reset_hist, reset_clock}, 0);

        run_cmd(8'h07, 64'h12345678);
        run_cmd(8'h01, 64'h50);
        run_cmd(8'h12, 0);
        run_cmd(8'h12, 0);

        histos = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'hA1B2C3D4};
        slow = 1;
        t0 = tx_cnt;
        run_cmd(8'h0A, 0);
        chk("histo_reply_len", tx_cnt - t0, HB + CKB);
        slow = 0;

        send(8'h0E);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        repeat (T) @(negedge clk);
        chk("timeout_not_early", busy, 1);
        @(negedge clk);
        chk("timeout_idle", busy, 0);
        err_inc();
        check_cfg();
        run_cmd(8'h12, 0);

        send(8'h00);
        rq.delete(); rq.push_back(FW); push_rq();
        send(8'h55);
        err_inc();
        wait_idle();
        run_cmd(8'h12, 0);

        for (int i = 0; i < 260; i++) begin send(8'hFF); err_inc(); end
        wait_idle();
        run_cmd(8'h12, 0);
        run_cmd(8'h11, 0);

        clock_counter = {$urandom, $urandom};
        trigger_fired = 8'($urandom);
        run_cmd(8'h0B, 64'h33);
        send(8'h10);
        rq.delete();
        for (int k = 0; k < 7; k++) rq.push_back(clock_counter[8*k +: 8]);
        rq.push_back(trigger_fired);
        push_rq();
        base = tx_cnt; n = 0;
        while (tx_cnt < base + 5 && n < 2000) begin @(negedge clk); n++; end
        chk("reply_progress", tx_cnt >= base + 5, 1);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); @(negedge clk);
        chk("midreply_tx_start", tx_start, 0);
        chk("midreply_busy", busy, 0);
        model_reset();
        check_cfg();
        #1 reset = 0;
        exp_q.delete();
        run_cmd(8'h00, 0);

        for (int it = 0; it < 60; it++) begin
            histos = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            clock_counter = {$urandom, $urandom};
            trigger_fired = 8'($urandom);
            case ($urandom_range(0, 10))
                0: c = 8'h00; 1: c = 8'h01; 2: c = 8'h07; 3: c = 8'h0A;
                4: c = 8'h0B; 5: c = 8'h0E; 6: c = 8'h0F; 7: c = 8'h10;
                8: c = 8'h11; 9: c = 8'h12;
                default: do c = 8'($urandom); while (c inside {8'h00, 8'h01, 8'h07, 8'h0A,
                         8'h0B, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12});
            endcase
            run_cmd(c, c == 8'h01 ? 64'($urandom_range(0, 127)) :
                       c == 8'h0F && $urandom_range(0, 3) == 0 ? 64'h0 : {$urandom, $urandom});
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
